// File: rtl/pipe_fwd_scoreboard.sv
// Hazard/forwarding scoreboard: tracks in-flight writers below decode, forwards the youngest
// matching result per read port, raises load-use stall. Optional macro: FWD_R0_ZERO_EN.
module pipe_fwd_scoreboard #(
    parameter int DSIZE      = 16,
    parameter int RSIZE      = 4,
    parameter int DEPTH      = 3,
    parameter int NREAD      = 2,
    parameter int LOAD_STAGE = 2
)(
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   issue_valid_i,
    input  logic                   issue_wen_i,
    input  logic [RSIZE-1:0]       issue_waddr_i,
    input  logic                   issue_load_i,
    input  logic                   flush_i,
    input  logic [NREAD*RSIZE-1:0] src_addr_i,
    input  logic [NREAD*DSIZE-1:0] rf_rdata_i,
    input  logic [DEPTH*DSIZE-1:0] stage_data_i,
    output logic [NREAD*DSIZE-1:0] fwd_data_o,
    output logic [NREAD-1:0]       fwd_hit_o,
    output logic                   stall_o,
    output logic [15:0]            stall_count_o
);

    logic [DEPTH-1:0]            vld_q, wen_q, load_q;
    logic [DEPTH-1:0][RSIZE-1:0] waddr_q;
    logic                        vld_d, wen_d;
    logic [15:0]                 cnt_q, cnt_d;
    logic [NREAD-1:0]            pend;

    // Scan oldest to youngest so the lowest matching entry is the last one to assign.
    always_comb begin
        fwd_data_o = rf_rdata_i;
        fwd_hit_o  = '0;
        pend       = '0;
        for (int p = 0; p < NREAD; p++) begin
            for (int k = DEPTH - 1; k >= 0; k--) begin
                if (vld_q[k] && wen_q[k] && (waddr_q[k] == src_addr_i[p*RSIZE +: RSIZE])) begin
                    if (load_q[k] && (k < LOAD_STAGE)) begin
                        fwd_data_o[p*DSIZE +: DSIZE] = rf_rdata_i[p*DSIZE +: DSIZE];
                        fwd_hit_o[p]                 = 1'b0;
                        pend[p]                      = 1'b1;
                    end else begin
                        fwd_data_o[p*DSIZE +: DSIZE] = stage_data_i[k*DSIZE +: DSIZE];
                        fwd_hit_o[p]                 = 1'b1;
                        pend[p]                      = 1'b0;
                    end
                end
            end
`ifdef FWD_R0_ZERO_EN
            if (src_addr_i[p*RSIZE +: RSIZE] == '0) begin
                fwd_data_o[p*DSIZE +: DSIZE] = '0;
                fwd_hit_o[p]                 = 1'b0;
                pend[p]                      = 1'b0;
            end
`endif
        end
    end

    assign stall_o       = issue_valid_i & (|pend);
    assign stall_count_o = cnt_q;

    always_comb begin
        vld_d = issue_valid_i & ~stall_o & ~flush_i;
`ifdef FWD_R0_ZERO_EN
        wen_d = issue_wen_i & (issue_waddr_i != '0);
`else
        wen_d = issue_wen_i;
`endif
        cnt_d = (stall_o && (cnt_q != 16'hFFFF)) ? cnt_q + 16'd1 : cnt_q;
    end

    // Stages below decode never hold: every entry advances each clock.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            vld_q   <= '0;
            wen_q   <= '0;
            load_q  <= '0;
            waddr_q <= '0;
            cnt_q   <= '0;
        end else begin
            vld_q   <= {vld_q[DEPTH-2:0], vld_d};
            wen_q   <= {wen_q[DEPTH-2:0], wen_d};
            load_q  <= {load_q[DEPTH-2:0], issue_load_i};
            waddr_q <= {waddr_q[DEPTH-2:0], issue_waddr_i};
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_pipe_fwd_scoreboard.sv
// Directed bench for pipe_fwd_scoreboard: vector table plus reset and stall-counter sequences.
module tb_pipe_fwd_scoreboard;

`ifdef FWD_R0_ZERO_EN
    localparam bit R0Z = 1'b1;
`else
    localparam bit R0Z = 1'b0;
`endif

    typedef struct {
        logic        v, w;
        logic [3:0]  wa;
        logic        ld, fl;
        logic [3:0]  s0, s1;
        logic [15:0] rf0, rf1, sd0, sd1, sd2;
        logic [15:0] e0, e1;
        logic [1:0]  eh;
        logic        es;
        logic [15:0] ec;
    } vec_t;

    logic        clk, rst;
    logic        issue_valid, issue_wen, issue_load, flush;
    logic [3:0]  issue_waddr;
    logic [7:0]  src_addr;
    logic [31:0] rf_rdata;
    logic [47:0] stage_data;
    logic [31:0] fwd_data;
    logic [1:0]  fwd_hit;
    logic        stall;
    logic [15:0] stall_count;

    // Deep instance used only to drive the stall counter into saturation quickly.
    logic        rst2;
    logic [31:0] s_fwd_data;
    logic [1:0]  s_fwd_hit;
    logic        s_stall;
    logic [15:0] s_count;

    int n_cmp = 0;
    int n_bad = 0;

    pipe_fwd_scoreboard dut (
        .clk_i(clk), .rst_i(rst),
        .issue_valid_i(issue_valid), .issue_wen_i(issue_wen), .issue_waddr_i(issue_waddr),
        .issue_load_i(issue_load), .flush_i(flush), .src_addr_i(src_addr),
        .rf_rdata_i(rf_rdata), .stage_data_i(stage_data),
        .fwd_data_o(fwd_data), .fwd_hit_o(fwd_hit), .stall_o(stall), .stall_count_o(stall_count)
    );

    pipe_fwd_scoreboard #(.DEPTH(16), .LOAD_STAGE(15)) dut_sat (
        .clk_i(clk), .rst_i(rst2),
        .issue_valid_i(1'b1), .issue_wen_i(1'b1), .issue_waddr_i(4'd5),
        .issue_load_i(1'b1), .flush_i(1'b0), .src_addr_i({4'd5, 4'd5}),
        .rf_rdata_i(32'h0), .stage_data_i({16{16'h0}}),
        .fwd_data_o(s_fwd_data), .fwd_hit_o(s_fwd_hit), .stall_o(s_stall), .stall_count_o(s_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic apply(input vec_t t);
        issue_valid = t.v;
        issue_wen   = t.w;
        issue_waddr = t.wa;
        issue_load  = t.ld;
        flush       = t.fl;
        src_addr    = {t.s1, t.s0};
        rf_rdata    = {t.rf1, t.rf0};
        stage_data  = {t.sd2, t.sd1, t.sd0};
    endtask

    task automatic chk_vec(input string nm, input vec_t t);
        chk({nm, " fwd0"},  {16'h0, fwd_data[15:0]},  {16'h0, t.e0});
        chk({nm, " fwd1"},  {16'h0, fwd_data[31:16]}, {16'h0, t.e1});
        chk({nm, " hit"},   {30'h0, fwd_hit},         {30'h0, t.eh});
        chk({nm, " stall"}, {31'h0, stall},           {31'h0, t.es});
        chk({nm, " cnt"},   {16'h0, stall_count},     {16'h0, t.ec});
    endtask

    vec_t tbl[18];
    vec_t h;

    initial begin
        //          v  w  wa  ld fl s0 s1 rf0       rf1       sd0       sd1       sd2       e0        e1        eh     es cnt
        tbl[0]  = '{0, 0, 0,  0, 0, 3, 4, 16'hA0A0, 16'hB0B0, 16'h0042, 16'h0001, 16'h0002, 16'hA0A0, 16'hB0B0, 2'b00, 0, 16'd0};
        tbl[1]  = '{1, 1, 3,  0, 0, 1, 2, 16'hA0A0, 16'hB0B0, 16'h0042, 16'h0001, 16'h0002, 16'hA0A0, 16'hB0B0, 2'b00, 0, 16'd0};
        tbl[2]  = '{1, 1, 6,  0, 0, 3, 5, 16'h1111, 16'h2222, 16'h0042, 16'h0001, 16'h0002, 16'h0042, 16'h2222, 2'b01, 0, 16'd0};
        tbl[3]  = '{1, 1, 3,  0, 0, 3, 6, 16'hA0A0, 16'hB0B0, 16'h1234, 16'h5678, 16'h0002, 16'h5678, 16'h1234, 2'b11, 0, 16'd0};
        tbl[4]  = '{0, 0, 0,  0, 0, 3, 6, 16'hA0A0, 16'hB0B0, 16'h0001, 16'h0777, 16'h0002, 16'h0001, 16'h0777, 2'b11, 0, 16'd0};
        tbl[5]  = '{1, 1, 7,  0, 1, 3, 7, 16'hA0A0, 16'hB0B0, 16'h0042, 16'h0555, 16'h0002, 16'h0555, 16'hB0B0, 2'b01, 0, 16'd0};
        tbl[6]  = '{0, 0, 0,  0, 0, 7, 3, 16'h7777, 16'hB0B0, 16'h0042, 16'h0001, 16'h0333, 16'h7777, 16'h0333, 2'b10, 0, 16'd0};
        tbl[7]  = '{1, 1, 5,  1, 0, 1, 2, 16'hA0A0, 16'hB0B0, 16'h0042, 16'h0001, 16'h0002, 16'hA0A0, 16'hB0B0, 2'b00, 0, 16'd0};
        tbl[8]  = '{1, 1, 8,  0, 0, 1, 2, 16'hA0A0, 16'hB0B0, 16'h0042, 16'h0001, 16'h0002, 16'hA0A0, 16'hB0B0, 2'b00, 0, 16'd0};
        tbl[9]  = '{1, 1, 9,  0, 0, 5, 8, 16'hA0A0, 16'hB0B0, 16'h0042, 16'h0001, 16'h0002, 16'hA0A0, 16'h0042, 2'b10, 1, 16'd0};
        tbl[10] = '{1, 1, 9,  0, 0, 5, 8, 16'hA0A0, 16'hB0B0, 16'h0042, 16'h0001, 16'hDA7A, 16'hDA7A, 16'h0001, 2'b11, 0, 16'd1};
        tbl[11] = '{1, 1, 5,  1, 0, 1, 2, 16'hA0A0, 16'hB0B0, 16'h0042, 16'h0001, 16'h0002, 16'hA0A0, 16'hB0B0, 2'b00, 0, 16'd1};
        tbl[12] = '{0, 0, 0,  0, 0, 5, 9, 16'hA0A0, 16'hB0B0, 16'h0042, 16'h0001, 16'h0002, 16'hA0A0, 16'h0001, 2'b10, 0, 16'd1};
        tbl[13] = '{1, 1, 10, 0, 1, 5, 9, 16'hA0A0, 16'hB0B0, 16'h0042, 16'h0001, 16'h0002, 16'hA0A0, 16'h0002, 2'b10, 1, 16'd1};
        tbl[14] = '{0, 0, 0,  0, 0, 5, 10,16'hA0A0, 16'hB0B0, 16'h0042, 16'h0001, 16'h0BAD, 16'h0BAD, 16'hB0B0, 2'b01, 0, 16'd2};
        tbl[15] = '{1, 1, 0,  0, 0, 1, 2, 16'hA0A0, 16'hB0B0, 16'h0042, 16'h0001, 16'h0002, 16'hA0A0, 16'hB0B0, 2'b00, 0, 16'd2};
        tbl[16] = '{1, 0, 0,  0, 0, 0, 2, 16'hBEEF, 16'hB0B0, 16'h0042, 16'h0001, 16'h0002,
                    R0Z ? 16'h0000 : 16'h0042, 16'hB0B0, R0Z ? 2'b00 : 2'b01, 0, 16'd2};
        tbl[17] = '{0, 0, 0,  0, 0, 0, 2, 16'hBEEF, 16'hB0B0, 16'h0042, 16'h0099, 16'h0002,
                    R0Z ? 16'h0000 : 16'h0099, 16'hB0B0, R0Z ? 2'b00 : 2'b01, 0, 16'd2};

        rst  = 1'b1;
        rst2 = 1'b1;
        apply(tbl[0]);
        #12 rst = 1'b0;

        for (int i = 0; i < 18; i++) begin
            @(posedge clk); #1;
            apply(tbl[i]);
            @(negedge clk);
            chk_vec($sformatf("v%0d", i), tbl[i]);
        end

        // Three valid entries (r1, load r4, r2) with a pending load-use, then async reset.
        h = '{1, 1, 2, 0, 0, 1, 3, 16'hCAFE, 16'hD00D, 16'h0042, 16'h0001, 16'h0002,
              16'h0, 16'h0, 2'b00, 0, 16'd0};
        @(posedge clk); #1; apply(h);
        h.wa = 4'd4; h.ld = 1'b1;
        @(posedge clk); #1; apply(h);
        h.wa = 4'd1; h.ld = 1'b0;
        @(posedge clk); #1; apply(h);
        h.wa = 4'd11; h.s0 = 4'd4; h.s1 = 4'd2;
        @(posedge clk); #1; apply(h);
        @(negedge clk);
        h.e0 = 16'hCAFE; h.e1 = 16'h0002; h.eh = 2'b10; h.es = 1'b1; h.ec = 16'd2;
        chk_vec("prerst", h);
        #1 rst = 1'b1;
        #1;
        h.e0 = 16'hCAFE; h.e1 = 16'hD00D; h.eh = 2'b00; h.es = 1'b0; h.ec = 16'd0;
        chk_vec("midrst", h);
        @(negedge clk); #1 rst = 1'b0;
        h.v = 1'b0; h.s0 = 4'd1; h.s1 = 4'd2;
        apply(h);
        @(posedge clk); @(negedge clk);
        chk_vec("postrst", h);

        // Period-16 pattern: one issuing cycle then 15 stall cycles.
        @(negedge clk); rst2 = 1'b0;
        repeat (1600) @(posedge clk);
        #1 chk("sat_cnt1600", {16'h0, s_count}, 32'd1500);
        repeat (68400) @(posedge clk);
        #1 chk("sat_cnt70000", {16'h0, s_count}, 32'h0000FFFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
